// File: rtl/arbitro_ram_pkg.sv
// Shared definitions for the cellular-RAM arbiter: pin widths, requester ids
// and the access sequencer's state encoding.
package paquete_ram;

  localparam int ANCHO_DIR    = 26;
  localparam int ANCHO_DATO   = 16;
  localparam int ANCHO_ESPERA = 4;
  localparam int ANCHO_CUENTA = 8;

  localparam logic ID_AUDIO = 1'b0;
  localparam logic ID_NOTAS = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_ESPERA  = 2'd2,
    ST_CAPTURA = 2'd3
  } estado_t;

  function automatic logic [ANCHO_CUENTA-1:0] incr_saturado(
    input logic [ANCHO_CUENTA-1:0] valor,
    input logic [ANCHO_CUENTA-1:0] tope
  );
    return (valor >= tope) ? tope : valor + 8'd1;
  endfunction

endpackage

// File: rtl/arbitro_ram_selector_prioridad.sv
// Winner selection between audio and notes, with the saturating run counter
// that bounds how long pending notes can be starved by audio.
module selector_prioridad
  import paquete_ram::*;
#(
  parameter int MAX_AUDIO = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en_idle_i,
  input  logic habilitar_i,
  input  logic req_audio_i,
  input  logic req_notas_i,
  output logic concede_o,
  output logic id_o
);

  localparam logic [ANCHO_CUENTA-1:0] TOPE = ANCHO_CUENTA'(MAX_AUDIO);

  logic [ANCHO_CUENTA-1:0] cuenta_audio_q, cuenta_audio_d;
  logic                    gana_notas;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    cuenta_audio_d = cuenta_audio_q;
    gana_notas     = req_notas_i && (!req_audio_i || (cuenta_audio_q >= TOPE));
    concede_o      = en_idle_i && habilitar_i && (req_audio_i || req_notas_i);
    id_o           = gana_notas ? ID_NOTAS : ID_AUDIO;

    // Audio grants only count while notes are actually waiting.
    if (concede_o && gana_notas) begin
      cuenta_audio_d = '0;
    end else if (en_idle_i && !req_notas_i) begin
      cuenta_audio_d = '0;
    end else if (concede_o) begin
      cuenta_audio_d = incr_saturado(cuenta_audio_q, TOPE);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cuenta_audio_q <= '0;
    end else begin
      cuenta_audio_q <= cuenta_audio_d;
    end
  end

endmodule

// File: rtl/arbitro_ram.sv
// Read-only arbiter/controller for the asynchronous cellular RAM shared by the
// audio sample streamer and the note-chart fetcher.
module arbitro_ram
  import paquete_ram::*;
#(
  parameter int WAIT_CYC  = 4,
  parameter int MAX_AUDIO = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  habilitar,
  input  logic                  req_audio,
  input  logic [ANCHO_DIR-1:0]  dir_audio,
  output logic                  ack_audio,
  input  logic                  req_notas,
  input  logic [ANCHO_DIR-1:0]  dir_notas,
  output logic                  ack_notas,
  output logic [ANCHO_DATO-1:0] dato_out,
  output logic                  ocupado,
  output logic [ANCHO_DIR-1:0]  DireccionRAM,
  input  logic [ANCHO_DATO-1:0] ram_dato,
  output logic                  ram_ce_n,
  output logic                  ram_oe_n,
  output logic                  ram_we_n,
  output logic                  ram_adv_n,
  output logic                  ram_lb_n,
  output logic                  ram_ub_n
);

  localparam logic [ANCHO_ESPERA-1:0] CARGA_ESPERA = ANCHO_ESPERA'(WAIT_CYC - 1);

  estado_t                 estado_q;
  logic [ANCHO_ESPERA-1:0] cuenta_espera_q;
  logic [ANCHO_DIR-1:0]    dir_q;
  logic [ANCHO_DATO-1:0]   dato_q;
  logic                    id_q;
  logic                    ack_audio_q, ack_notas_q;
  logic                    ce_n_q, oe_n_q;

  logic                    concede;
  logic                    id_ganador;
  logic [ANCHO_DIR-1:0]    dir_ganador;

  selector_prioridad #(
    .MAX_AUDIO (MAX_AUDIO)
  ) u_selector (
    .clk         (clk),
    .reset       (reset),
    .en_idle_i   (estado_q == ST_IDLE),
    .habilitar_i (habilitar),
    .req_audio_i (req_audio),
    .req_notas_i (req_notas),
    .concede_o   (concede),
    .id_o        (id_ganador)
  );

  assign dir_ganador = (id_ganador == ID_NOTAS) ? dir_notas : dir_audio;

  // Strobes are registered so CE/OE change on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q        <= ST_IDLE;
      cuenta_espera_q <= '0;
      dir_q           <= '0;
      dato_q          <= '0;
      id_q            <= ID_AUDIO;
      ack_audio_q     <= 1'b0;
      ack_notas_q     <= 1'b0;
      ce_n_q          <= 1'b1;
      oe_n_q          <= 1'b1;
    end else begin
      ack_audio_q <= 1'b0;
      ack_notas_q <= 1'b0;
      case (estado_q)
        ST_IDLE: begin
          ce_n_q <= 1'b1;
          oe_n_q <= 1'b1;
          if (concede) begin
            dir_q    <= dir_ganador;
            id_q     <= id_ganador;
            ce_n_q   <= 1'b0;
            oe_n_q   <= 1'b0;
            estado_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          cuenta_espera_q <= CARGA_ESPERA;
          estado_q        <= ST_ESPERA;
        end
        ST_ESPERA: begin
          if (cuenta_espera_q == '0) begin
            estado_q <= ST_CAPTURA;
          end else begin
            cuenta_espera_q <= cuenta_espera_q - 4'd1;
          end
        end
        ST_CAPTURA: begin
          dato_q      <= ram_dato;
          ack_audio_q <= (id_q == ID_AUDIO);
          ack_notas_q <= (id_q == ID_NOTAS);
          ce_n_q      <= 1'b1;
          oe_n_q      <= 1'b1;
          estado_q    <= ST_IDLE;
        end
        default: begin
          estado_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack_audio    = ack_audio_q;
  assign ack_notas    = ack_notas_q;
  assign dato_out     = dato_q;
  assign ocupado      = (estado_q != ST_IDLE);
  assign DireccionRAM = dir_q;
  assign ram_ce_n     = ce_n_q;
  assign ram_oe_n     = oe_n_q;

  // Asynchronous mode, full-word reads only.
  assign ram_we_n  = 1'b1;
  assign ram_adv_n = 1'b0;
  assign ram_lb_n  = 1'b0;
  assign ram_ub_n  = 1'b0;

endmodule
